regfile_mp: RTL and testbench

- Parametrised multi-port general-purpose register file for the pipelined datapath; successor to the 2-read/1-write register file.
- Adds NUM_RD read ports, NUM_WR write ports with fixed priority, and same-cycle write-to-read bypass.
- Adds asynchronous clear of all registers and a per-register busy scoreboard (set at issue, cleared at writeback), so decode can detect RAW hazards without an external table.

---
 rtl/regfile_pkg.sv | 34 +++
 rtl/regfile_scoreboard.sv | 61 ++++++
 rtl/regfile_mp.sv | 112 +++++++++++
 tb/tb_regfile_mp.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and write-port priority helper for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    // Upper bound on write ports handled by the priority helper.
    localparam int MAX_WR     = 8;
    localparam int WR_IDX_W   = 3;

    typedef struct packed {
        logic                found;
        logic [WR_IDX_W-1:0] idx;
    } wr_sel_t;

    // Pick the highest-index asserted bit of a per-port hit vector.
    // Used both for storage updates and for read bypass so they always agree.
    function automatic wr_sel_t hi_port(input logic [MAX_WR-1:0] hit);
        wr_sel_t sel;
        sel.found = 1'b0;
        sel.idx   = {WR_IDX_W{1'b0}};
        for (int j = 0; j < MAX_WR; j++) begin
            if (hit[j]) begin
                sel.found = 1'b1;
                sel.idx   = WR_IDX_W'(j);
            end else begin
                sel.found = sel.found;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits (set at issue, cleared at writeback) and a registered busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IssueValid,
    input  logic [ADDR_W-1:0]     IssueReg,
    input  logic [2**ADDR_W-1:0]  clr,
    output logic [2**ADDR_W-1:0]  busy,
    output logic [ADDR_W:0]       BusyCount
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic [ADDR_W:0]  cnt_nxt_s;
    logic [ADDR_W:0]  cnt_r;

    // Next busy state: clear on writeback first, then a new issue overrides the clear.
    always_comb begin
        busy_nxt_s = busy_r & ~clr;
        if (IssueValid) begin
            busy_nxt_s[IssueReg] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (ZERO_REG != 0) begin
            busy_nxt_s[0] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Population count of the next-state busy vector.
    always_comb begin
        cnt_nxt_s = {(ADDR_W + 1){1'b0}};
        for (int k = 0; k < NREGS; k++) begin
            cnt_nxt_s = cnt_nxt_s + (ADDR_W + 1)'(busy_nxt_s[k]);
        end
    end

    // Busy bits and count register; reset drops any in-flight update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {NREGS{1'b0}};
            cnt_r  <= {(ADDR_W + 1){1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign busy      = busy_r;
    assign BusyCount = cnt_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with prioritized writes, optional write-to-read bypass
// and an integrated busy scoreboard for RAW hazard detection.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   ReadReg,
    output logic [NUM_RD*DATA_W-1:0]   ReadData,
    output logic [NUM_RD-1:0]          ReadBusy,
    input  logic [NUM_WR-1:0]          RegWrite,
    input  logic [NUM_WR*ADDR_W-1:0]   WriteReg,
    input  logic [NUM_WR*DATA_W-1:0]   WriteData,
    input  logic                       IssueValid,
    input  logic [ADDR_W-1:0]          IssueReg,
    output logic [ADDR_W:0]            BusyCount
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r    [NREGS];
    logic [DATA_W-1:0] wr_val_s [NREGS];
    logic [NREGS-1:0]  wr_en_s;
    logic [NREGS-1:0]  clr_s;
    logic [NREGS-1:0]  busy_s;

    // Per-register write select: highest-index enabled port targeting the register wins.
    always_comb begin
        logic [MAX_WR-1:0] hit;
        wr_sel_t           sel;
        wr_en_s = {NREGS{1'b0}};
        clr_s   = {NREGS{1'b0}};
        for (int k = 0; k < NREGS; k++) begin
            hit = {MAX_WR{1'b0}};
            for (int j = 0; j < NUM_WR; j++) begin
                hit[j] = RegWrite[j] && (WriteReg[j*ADDR_W +: ADDR_W] == ADDR_W'(k));
            end
            sel         = hi_port(hit);
            clr_s[k]    = sel.found;
            wr_val_s[k] = WriteData[int'(sel.idx)*DATA_W +: DATA_W];
            if ((ZERO_REG != 0) && (k == 0)) begin
                wr_en_s[k] = 1'b0;
            end else begin
                wr_en_s[k] = sel.found;
            end
        end
    end

    // Register storage; reset clears every entry immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                mem_r[k] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (wr_en_s[k]) begin
                    mem_r[k] <= wr_val_s[k];
                end else begin
                    mem_r[k] <= mem_r[k];
                end
            end
        end
    end

    // Read ports: hardwired zero first, then same-cycle bypass, then stored value.
    always_comb begin
        logic [ADDR_W-1:0] addr;
        logic [MAX_WR-1:0] hit;
        wr_sel_t           sel;
        ReadData = {(NUM_RD*DATA_W){1'b0}};
        ReadBusy = {NUM_RD{1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
            addr = ReadReg[i*ADDR_W +: ADDR_W];
            hit  = {MAX_WR{1'b0}};
            for (int j = 0; j < NUM_WR; j++) begin
                hit[j] = RegWrite[j] && (WriteReg[j*ADDR_W +: ADDR_W] == addr);
            end
            sel = hi_port(hit);
            if ((ZERO_REG != 0) && (addr == {ADDR_W{1'b0}})) begin
                ReadData[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if ((BYPASS != 0) && sel.found) begin
                ReadData[i*DATA_W +: DATA_W] = WriteData[int'(sel.idx)*DATA_W +: DATA_W];
            end else begin
                ReadData[i*DATA_W +: DATA_W] = mem_r[addr];
            end
            // Busy reflects registered state only; a same-cycle writeback is not seen yet.
            ReadBusy[i] = busy_s[addr];
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .IssueValid (IssueValid),
        .IssueReg   (IssueReg),
        .clr        (clr_s),
        .busy       (busy_s),
        .BusyCount  (BusyCount)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expectations, a negedge monitor checks them.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ReadReg;
    logic [1:0]  RegWrite;
    logic [9:0]  WriteReg;
    logic [63:0] WriteData;
    logic        IssueValid;
    logic [4:0]  IssueReg;

    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic [5:0]  busy_cnt, busy_cnt_nb;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ReadReg(ReadReg), .ReadData(rd_data), .ReadBusy(rd_busy),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .IssueValid(IssueValid), .IssueReg(IssueReg), .BusyCount(busy_cnt));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ReadReg(ReadReg), .ReadData(rd_data_nb), .ReadBusy(rd_busy_nb),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .IssueValid(IssueValid), .IssueReg(IssueReg), .BusyCount(busy_cnt_nb));

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int kind);
        case (kind)
            0: return "rdata";
            1: return "rdata_nobypass";
            2: return "rbusy";
            3: return "busycount";
            4: return "rbusy_nobypass";
            5: return "busycount_nobypass";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: pop every expectation issued for the current cycle and compare.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            case (e.kind)
                0: act = rd_data[e.port*32 +: 32];
                1: act = rd_data_nb[e.port*32 +: 32];
                2: act = {31'd0, rd_busy[e.port]};
                3: act = {26'd0, busy_cnt};
                4: act = {31'd0, rd_busy_nb[e.port]};
                5: act = {26'd0, busy_cnt_nb};
                default: act = 32'hxxxx_xxxx;
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s port%0d cyc%0d: got %h expected %h",
                         kname(e.kind), e.port, e.cyc, act, e.val);
            end
        end
    end

    task automatic push(input int kind, input int port, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.port = port; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic exp_rd(input int p, input logic [31:0] v);   push(0, p, v); endtask
    task automatic exp_nb(input int p, input logic [31:0] v);   push(1, p, v); endtask
    task automatic exp_busy(input int p, input logic v);        push(2, p, {31'd0, v}); push(4, p, {31'd0, v}); endtask
    task automatic exp_cnt(input int v);                        push(3, 0, v); push(5, 0, v); endtask

    // Start of a new cycle: shortly after the rising edge, with enables cleared.
    task automatic nxt();
        @(posedge clk);
        #1;
        RegWrite   = 2'b00;
        IssueValid = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        ReadReg = {a1, a0};
    endtask

    task automatic wr(input int j, input logic [4:0] a, input logic [31:0] d);
        RegWrite[j]          = 1'b1;
        WriteReg[j*5 +: 5]   = a;
        WriteData[j*32 +: 32] = d;
    endtask

    task automatic issue(input logic [4:0] a);
        IssueValid = 1'b1;
        IssueReg   = a;
    endtask

    // Reference model state for the random phase.
    logic [31:0] m_mem  [32];
    logic        m_busy [32];
    int          m_cnt;

    initial begin
        rst = 1'b1; ReadReg = 10'd0; RegWrite = 2'b00; WriteReg = 10'd0;
        WriteData = 64'd0; IssueValid = 1'b0; IssueReg = 5'd0;
        repeat (2) @(posedge clk);

        // Out of reset: everything reads zero and nothing is busy.
        nxt(); rst = 1'b0; set_rd(5'd3, 5'd0);
        exp_rd(0, 32'h0); exp_rd(1, 32'h0); exp_busy(0, 1'b0); exp_cnt(0);

        // Write r3 and attempt r0; bypass shows r3 at once, r0 stays zero.
        nxt(); wr(0, 5'd3, 32'h1234_5678); wr(1, 5'd0, 32'hFFFF_FFFF); set_rd(5'd3, 5'd0);
        exp_rd(0, 32'h1234_5678); exp_nb(0, 32'h0); exp_rd(1, 32'h0); exp_nb(1, 32'h0);

        nxt(); set_rd(5'd3, 5'd0);
        exp_rd(0, 32'h1234_5678); exp_nb(0, 32'h1234_5678); exp_rd(1, 32'h0); exp_nb(1, 32'h0);

        // Both ports hit r7: port 1 wins, for storage and for bypass.
        nxt(); wr(0, 5'd7, 32'h1111); wr(1, 5'd7, 32'h2222); set_rd(5'd7, 5'd3);
        exp_rd(0, 32'h2222); exp_nb(0, 32'h0);

        nxt(); set_rd(5'd7, 5'd3);
        exp_rd(0, 32'h2222); exp_nb(0, 32'h2222); exp_rd(1, 32'h1234_5678);

        // Issue r9: busy appears on the following cycle.
        nxt(); issue(5'd9); set_rd(5'd9, 5'd0);
        exp_busy(0, 1'b0); exp_cnt(0);

        nxt(); set_rd(5'd9, 5'd0);
        exp_busy(0, 1'b1); exp_cnt(1);

        // Writeback r9: data bypassed, busy still registered-high this cycle.
        nxt(); wr(0, 5'd9, 32'hAAAA); set_rd(5'd9, 5'd0);
        exp_busy(0, 1'b1); exp_cnt(1); exp_rd(0, 32'hAAAA); exp_nb(0, 32'h0);

        nxt(); set_rd(5'd9, 5'd0);
        exp_busy(0, 1'b0); exp_cnt(0); exp_rd(0, 32'hAAAA);

        // Make r4 busy, then issue and write it back together: set wins.
        nxt(); issue(5'd4); set_rd(5'd4, 5'd0);
        nxt(); set_rd(5'd4, 5'd0);
        exp_busy(0, 1'b1); exp_cnt(1);

        nxt(); issue(5'd4); wr(1, 5'd4, 32'hBBBB); set_rd(5'd4, 5'd0);
        exp_busy(0, 1'b1); exp_cnt(1); exp_rd(0, 32'hBBBB); exp_nb(0, 32'h0);

        nxt(); set_rd(5'd4, 5'd0);
        exp_busy(0, 1'b1); exp_cnt(1); exp_rd(0, 32'hBBBB); exp_nb(0, 32'hBBBB);

        // Issue to r0 is ignored; writeback to a non-busy register just writes.
        nxt(); issue(5'd0); wr(0, 5'd10, 32'h5555); set_rd(5'd10, 5'd0);
        nxt(); set_rd(5'd10, 5'd0);
        exp_rd(0, 32'h5555); exp_busy(0, 1'b0); exp_busy(1, 1'b0); exp_cnt(1);

        // Two ports to different addresses both land.
        nxt(); wr(0, 5'd11, 32'h0B); wr(1, 5'd12, 32'h0C); set_rd(5'd11, 5'd12);
        nxt(); set_rd(5'd11, 5'd12);
        exp_rd(0, 32'h0B); exp_rd(1, 32'h0C); exp_nb(0, 32'h0B); exp_nb(1, 32'h0C);

        // Retire r4.
        nxt(); wr(0, 5'd4, 32'h0); set_rd(5'd4, 5'd0);
        nxt(); set_rd(5'd4, 5'd0);
        exp_busy(0, 1'b0); exp_cnt(0);

        // Reset mid-run: clears data and busy without waiting for a clock edge.
        nxt(); wr(0, 5'd5, 32'hDEAD_BEEF); issue(5'd6); set_rd(5'd5, 5'd6);
        nxt(); set_rd(5'd5, 5'd6);
        exp_rd(0, 32'hDEAD_BEEF); exp_busy(1, 1'b1); exp_cnt(1);
        nxt(); rst = 1'b1; set_rd(5'd5, 5'd6);
        exp_rd(0, 32'h0); exp_nb(0, 32'h0); exp_busy(1, 1'b0); exp_cnt(0);
        nxt(); rst = 1'b0; set_rd(5'd5, 5'd3);
        exp_rd(0, 32'h0); exp_rd(1, 32'h0); exp_cnt(0);

        // Random phase against a reference model starting from the cleared state.
        for (int k = 0; k < 32; k++) begin
            m_mem[k] = 32'd0;
            m_busy[k] = 1'b0;
        end
        m_cnt = 0;
        for (int n = 0; n < 1500; n++) begin
            logic [4:0]  wa [2];
            logic [31:0] wd [2];
            logic        we [2];
            logic [4:0]  ra, ir;
            logic [31:0] v;
            logic        iv;
            nxt();
            for (int j = 0; j < 2; j++) begin
                we[j] = 1'($urandom_range(0, 1));
                wa[j] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                wd[j] = $urandom;
                if (we[j]) wr(j, wa[j], wd[j]);
            end
            iv = 1'($urandom_range(0, 1));
            ir = 5'($urandom_range(0, 7));
            if (iv) issue(ir);
            for (int p = 0; p < 2; p++) begin
                ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                ReadReg[p*5 +: 5] = ra;
                v = m_mem[ra];
                exp_nb(p, (ra == 5'd0) ? 32'd0 : v);
                for (int j = 0; j < 2; j++) if (we[j] && wa[j] == ra) v = wd[j];
                exp_rd(p, (ra == 5'd0) ? 32'd0 : v);
                exp_busy(p, m_busy[ra]);
            end
            exp_cnt(m_cnt);
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wa[j] != 5'd0) m_mem[wa[j]] = wd[j];
                if (we[j]) m_busy[wa[j]] = 1'b0;
            end
            if (iv && ir != 5'd0) m_busy[ir] = 1'b1;
            m_cnt = 0;
            for (int k = 0; k < 32; k++) m_cnt += int'(m_busy[k]);
        end

        nxt();
        nxt();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
